fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the core. It holds the PC, issues word fetches to instruction memory, and buffers returned instructions in an in-order queue. It presents each instruction with its PC to decode over a valid/ready handshake. Decode and immgen consume its output; execute redirects it on taken branches, JALR, and mispredicts.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `QUEUE_DEPTH`, default `4`: instruction queue slots; a power of 2, at least 2.
- `clk` in 1: clock; all state changes on the rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word address, bits [1:0] always 0.
- `imem_rsp_valid` in 1: response data valid. Responses are in order and cannot be back-pressured.
- `imem_rsp_data` in 32: fetched instruction.
- `redirect_valid` in 1: flush request from execute.
- `redirect_pc` in 32: new fetch PC.
- `instr_valid` out 1: queue head is valid.
- `instr_ready` in 1: decode accepts the head.
- `instr` out 32: head instruction.
- `instr_pc` out 32: head PC.
- `instr_pred_taken` out 1: head was a JAL that fetch already followed.

## Operation
- **Queue slots.** Each slot holds {pc, instr, filled}.
  - A slot is allocated when a request is accepted (`imem_req_valid && imem_req_ready`).
  - Its pc is written at allocation.
  - Responses fill slots in allocation order using a separate fill pointer.
- **Request issue.** `imem_req_valid` = reset released && allocated slots < `QUEUE_DEPTH` && !`redirect_valid`.
  - `imem_req_addr` = PC.
  - On accept, PC ← PC+4. Wrap from `32'hFFFF_FFFC` to 0.
- **Decode output.** `instr_valid` = head slot filled && !`redirect_valid`.
  - A handshake (`instr_valid && instr_ready`) frees the head slot.
  - Allocate and free may happen in the same cycle.
- **Redirect.** When `redirect_valid`:
  - PC ← {`redirect_pc`[31:2], 2'b00}.
  - All slots are cleared.
  - drop_count ← responses still outstanding, excluding any arriving this cycle.
  - A response arriving in the redirect cycle is discarded.
  - A redirect overrides any simultaneous JAL predecode redirect.
- **Dropping stale responses.** While drop_count > 0, each `imem_rsp_valid` decrements drop_count and writes nothing.
  - New requests may be issued while drop_count > 0.
  - The queue occupancy limit counts outstanding dropped responses as occupied, so the queue never overflows.

## Timing
- **Reset values.**
  - `imem_req_valid`=0, `instr_valid`=0, `instr_pred_taken`=0.
  - `instr`=0, `instr_pc`=0, `imem_req_addr`=`RESET_PC`.
  - PC=`RESET_PC`, drop_count=0, queue empty.
- **Reset mid-operation.** Asserting reset with requests in flight returns everything to the reset values immediately. Responses arriving after reset release with nothing outstanding are ignored.
- **First request.** `imem_req_valid` rises in the first cycle after `rstn` deasserts.
- **Latency.** Request accepted at edge t; response at earliest cycle t+1. A response at cycle r makes `instr_valid` high from cycle r+1, because slot fill is registered.
- **Throughput.** One instruction per cycle sustained with single-cycle memory and `instr_ready`=1.
- **Redirect timing.** A redirect at cycle c gives the first new request in cycle c+1.

## Configuration
- **`FETCH_JAL_PREDECODE_EN` defined:** when a filled response has opcode `7'b1101111`:
  - The slot's pred_taken flag is set.
  - Every slot allocated after it is freed, and drop_count increments by the number of those still unfilled.
  - PC ← slot pc + J-immediate, where the J-immediate is {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}.
  - Request issue is suppressed in that cycle.
- **Not defined:** fetch is purely sequential and `instr_pred_taken` is tied to 0.

## Test plan
- **Reset and stream.** Release reset with memory ready and 1-cycle latency, `instr_ready`=1 → addresses 0,4,8,… issue on consecutive cycles; the first `instr_valid` arrives 2 cycles after the first accept, with `instr_pc`=0.
- **Back-pressure.** `instr_ready`=0, depth 4 → exactly 4 requests accepted, then `imem_req_valid` stays 0; one dequeue allows exactly one more request.
- **Redirect with outstanding responses.** Redirect to `0x100` with 2 responses outstanding (3-cycle latency) → both are dropped, the next delivered `instr_pc`=`0x100`, and `instr_valid` is 0 during the redirect cycle.
- **Redirect collision.** Redirect in the same cycle as a response and a decode handshake → response discarded, no handshake completes, queue empty afterwards.
- **JAL predecode (macro defined).** `0x0080006F` fetched at PC `0x10` → delivered with `instr_pred_taken`=1; the next delivered `instr_pc`=`0x18`, and the `0x14` response is dropped. With the macro undefined the next delivered PC is `0x14`.
- **Reset mid-run.** Assert `rstn`=0 mid-run with 3 requests in flight → all outputs return to reset values immediately; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch stage. Holds the PC, issues word fetches to
//             instruction memory, buffers returned words in an in-order
//             queue and hands them to decode over a valid/ready handshake.
//             Optional macro FETCH_JAL_PREDECODE_EN follows JAL instructions
//             at fetch time.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_pred_taken
);

    localparam int                 c_PTR_W   = $clog2(QUEUE_DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]   c_DEPTH_X = (c_CNT_W + 1)'(QUEUE_DEPTH);

    // PC and slot PCs are word addresses; the low two bits are always zero.
    logic [29:0]              r_pc;
    logic [29:0]              r_slot_pc    [QUEUE_DEPTH];
    logic [31:0]              r_slot_instr [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]   r_slot_filled;
    logic [c_PTR_W-1:0]       r_head;
    logic [c_PTR_W-1:0]       r_tail;
    logic [c_PTR_W-1:0]       r_fill;
    logic [c_CNT_W-1:0]       r_count;      // allocated slots
    logic [c_CNT_W-1:0]       r_pending;    // allocated slots awaiting data
    logic [c_CNT_W-1:0]       r_drop;       // stale responses still to discard

    logic                     w_req_valid;
    logic                     w_accept;
    logic                     w_head_filled;
    logic                     w_deq;
    logic                     w_rsp_drop;
    logic                     w_rsp_fill;
    logic [c_CNT_W:0]         w_occupied;
    logic [c_CNT_W-1:0]       w_outstanding;
    logic [c_PTR_W-1:0]       w_fill_rel;
    logic [c_CNT_W-1:0]       w_jal_after;
    logic [c_CNT_W-1:0]       w_jal_cut;
    logic                     w_jal_hit;
    logic [31:0]              w_jal_target;
    logic [3:0]               w_unused_bits;

    // Dropped responses still count as occupied so the queue cannot overflow.
    assign w_occupied    = {1'b0, r_count} + {1'b0, r_drop};
    assign w_outstanding = r_pending + r_drop;
    assign w_req_valid   = rstn && (w_occupied < c_DEPTH_X) && !redirect_valid && !w_jal_hit;
    assign w_accept      = w_req_valid && imem_req_ready;
    assign w_head_filled = r_slot_filled[r_head];
    assign w_deq         = w_head_filled && !redirect_valid && instr_ready;
    assign w_rsp_drop    = imem_rsp_valid && (r_drop != '0);
    // A response with nothing outstanding (e.g. after reset) is ignored.
    assign w_rsp_fill    = imem_rsp_valid && (r_drop == '0) && (r_pending != '0);

    // Slots allocated after the filling slot, all of which are still unfilled.
    assign w_fill_rel    = r_fill - r_head;
    assign w_jal_after   = r_count - {1'b0, w_fill_rel} - c_CNT_W'(1);
    assign w_jal_cut     = w_jal_hit ? w_jal_after : '0;

`ifdef FETCH_JAL_PREDECODE_EN
    logic [31:0]            w_jal_imm;
    logic [QUEUE_DEPTH-1:0] r_slot_pred;

    assign w_jal_hit    = w_rsp_fill && !redirect_valid && (imem_rsp_data[6:0] == 7'b1101111);
    assign w_jal_imm    = {{12{imem_rsp_data[31]}}, imem_rsp_data[19:12], imem_rsp_data[20],
                           imem_rsp_data[30:21], 1'b0};
    assign w_jal_target = {r_slot_pc[r_fill], 2'b00} + w_jal_imm;

    // Record per slot whether fetch already followed it as a JAL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_slot_pred <= '0;
        end else if (w_rsp_fill && !redirect_valid) begin
            r_slot_pred[r_fill] <= w_jal_hit;
        end
    end

    assign instr_pred_taken = r_slot_pred[r_head] && w_head_filled;
`else
    assign w_jal_hit        = 1'b0;
    assign w_jal_target     = 32'h0000_0000;
    assign instr_pred_taken = 1'b0;
`endif

    assign w_unused_bits  = {redirect_pc[1:0], w_jal_target[1:0]};

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = {r_pc, 2'b00};
    assign instr_valid    = w_head_filled && !redirect_valid;
    assign instr          = r_slot_instr[r_head];
    assign instr_pc       = {r_slot_pc[r_head], 2'b00};

    // PC, queue pointers, occupancy and drop accounting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc          <= RESET_PC[31:2];
            r_head        <= '0;
            r_tail        <= '0;
            r_fill        <= '0;
            r_count       <= '0;
            r_pending     <= '0;
            r_drop        <= '0;
            r_slot_filled <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_slot_pc[i]    <= '0;
                r_slot_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Flush: everything in flight becomes stale, except a response
            // arriving right now, which is discarded here.
            r_pc          <= redirect_pc[31:2];
            r_head        <= '0;
            r_tail        <= '0;
            r_fill        <= '0;
            r_count       <= '0;
            r_pending     <= '0;
            r_slot_filled <= '0;
            r_drop        <= (imem_rsp_valid && (w_outstanding != '0)) ?
                             w_outstanding - c_CNT_W'(1) : w_outstanding;
        end else begin
            if (w_jal_hit) begin
                r_pc <= w_jal_target[31:2];
            end else if (w_accept) begin
                r_pc <= r_pc + 30'd1;
            end
            if (w_accept) begin
                r_slot_pc[r_tail]     <= r_pc;
                r_slot_filled[r_tail] <= 1'b0;
            end
            if (w_rsp_fill) begin
                r_slot_instr[r_fill]  <= imem_rsp_data;
                r_slot_filled[r_fill] <= 1'b1;
            end
            if (w_deq) begin
                r_slot_filled[r_head] <= 1'b0;
            end
            r_tail    <= w_jal_hit ? r_fill + c_PTR_W'(1) : r_tail + c_PTR_W'(w_accept);
            r_fill    <= r_fill + c_PTR_W'(w_rsp_fill);
            r_head    <= r_head + c_PTR_W'(w_deq);
            r_count   <= r_count + c_CNT_W'(w_accept) - c_CNT_W'(w_deq) - w_jal_cut;
            r_pending <= r_pending + c_CNT_W'(w_accept) - c_CNT_W'(w_rsp_fill) - w_jal_cut;
            r_drop    <= r_drop - c_CNT_W'(w_rsp_drop) + w_jal_cut;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Cycle-by-cycle directed vectors for fetch_unit: streaming,
//             back-pressure, redirects, JAL predecode and reset mid-run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

`ifdef FETCH_JAL_PREDECODE_EN
    localparam logic c_JAL = 1'b1;
`else
    localparam logic c_JAL = 1'b0;
`endif
    localparam logic [31:0] c_JAL_WORD = 32'h0080_006F;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_pred_taken;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit dut (
        .clk              (clk),
        .rstn             (rstn),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_pred_taken (instr_pred_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        redir;
        logic [31:0] redir_pc;
        logic        instr_ready;
        logic        e_req_valid;
        logic [31:0] e_addr;
        logic        e_instr_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_pred;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] d(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic vec_t mk(input logic rs, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic rr,
                                input logic [31:0] rpc, input logic ir,
                                input logic erv, input logic [31:0] ea,
                                input logic eiv, input logic [31:0] ei,
                                input logic [31:0] ep, input logic epr);
        vec_t v;
        v.rstn = rs;  v.req_ready = rdy; v.rsp_valid = rv; v.rsp_data = rd;
        v.redir = rr; v.redir_pc = rpc;  v.instr_ready = ir;
        v.e_req_valid = erv; v.e_addr = ea; v.e_instr_valid = eiv;
        v.e_instr = ei; v.e_pc = ep; v.e_pred = epr;
        return v;
    endfunction

    task automatic chk(input int idx, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL v%0d %s: got %h, expected %h", idx, name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        rstn           = v.rstn;
        imem_req_ready = v.req_ready;
        imem_rsp_valid = v.rsp_valid;
        imem_rsp_data  = v.rsp_data;
        redirect_valid = v.redir;
        redirect_pc    = v.redir_pc;
        instr_ready    = v.instr_ready;
        #1;
        n_vec++;
        chk(idx, "req_valid", 32'(imem_req_valid), 32'(v.e_req_valid));
        chk(idx, "req_addr", imem_req_addr, v.e_addr);
        chk(idx, "instr_valid", 32'(instr_valid), 32'(v.e_instr_valid));
        if (v.e_instr_valid || !v.rstn) begin
            chk(idx, "instr", instr, v.e_instr);
            chk(idx, "instr_pc", instr_pc, v.e_pc);
            chk(idx, "pred_taken", 32'(instr_pred_taken), 32'(v.e_pred));
        end
    endtask

    initial begin
        // Reset state
        vecs.push_back(mk(0,1,0,0,        0,0,1, 0,32'h0,   0,0,0,0));
        // Stream with 1-cycle memory, decode always ready
        vecs.push_back(mk(1,1,0,0,        0,0,1, 1,32'h0,   0,0,0,0));
        vecs.push_back(mk(1,1,1,d(32'h0), 0,0,1, 1,32'h4,   0,0,0,0));
        vecs.push_back(mk(1,1,1,d(32'h4), 0,0,1, 1,32'h8,   1,d(32'h0),32'h0,0));
        vecs.push_back(mk(1,1,1,d(32'h8), 0,0,1, 1,32'hC,   1,d(32'h4),32'h4,0));
        vecs.push_back(mk(1,1,1,d(32'hC), 0,0,1, 1,32'h10,  1,d(32'h8),32'h8,0));
        vecs.push_back(mk(1,0,1,d(32'h10),0,0,1, 1,32'h14,  1,d(32'hC),32'hC,0));
        vecs.push_back(mk(1,0,0,0,        0,0,1, 1,32'h14,  1,d(32'h10),32'h10,0));
        // Back-pressure: four accepts fill the queue, one dequeue admits one more
        vecs.push_back(mk(1,1,0,0,        0,0,0, 1,32'h14,  0,0,0,0));
        vecs.push_back(mk(1,1,1,d(32'h14),0,0,0, 1,32'h18,  0,0,0,0));
        vecs.push_back(mk(1,1,1,d(32'h18),0,0,0, 1,32'h1C,  1,d(32'h14),32'h14,0));
        vecs.push_back(mk(1,1,1,d(32'h1C),0,0,0, 1,32'h20,  1,d(32'h14),32'h14,0));
        vecs.push_back(mk(1,1,1,d(32'h20),0,0,0, 0,32'h24,  1,d(32'h14),32'h14,0));
        vecs.push_back(mk(1,1,0,0,        0,0,1, 0,32'h24,  1,d(32'h14),32'h14,0));
        vecs.push_back(mk(1,1,0,0,        0,0,0, 1,32'h24,  1,d(32'h18),32'h18,0));
        // Redirect colliding with a response and a ready decode
        vecs.push_back(mk(1,1,1,d(32'h24),1,32'h40,1, 0,32'h28, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,        0,0,1, 1,32'h40,  0,0,0,0));
        // Redirect with two responses outstanding (3-cycle memory)
        vecs.push_back(mk(1,1,0,0,        0,0,1, 1,32'h44,  0,0,0,0));
        vecs.push_back(mk(1,1,0,0,        1,32'h100,1, 0,32'h48, 0,0,0,0));
        vecs.push_back(mk(1,1,1,d(32'h40),0,0,1, 1,32'h100, 0,0,0,0));
        vecs.push_back(mk(1,0,1,d(32'h44),0,0,1, 1,32'h104, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,        0,0,1, 1,32'h104, 0,0,0,0));
        vecs.push_back(mk(1,0,1,d(32'h100),0,0,1,1,32'h104, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,        0,0,1, 1,32'h104, 1,d(32'h100),32'h100,0));
        vecs.push_back(mk(1,0,0,0,        0,0,1, 1,32'h104, 0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // JAL at 0x10 with 2-cycle memory; 0x14 is already in flight
        vecs.delete();
        vecs.push_back(mk(1,0,0,0,          1,32'h10,0, 0,32'h104, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,          0,0,0, 1,32'h10, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,          0,0,0, 1,32'h14, 0,0,0,0));
        vecs.push_back(mk(1,0,1,c_JAL_WORD, 0,0,0, !c_JAL,32'h18, 0,0,0,0));
        vecs.push_back(mk(1,0,1,d(32'h14),  0,0,1, 1,32'h18, 1,c_JAL_WORD,32'h10,c_JAL));
        vecs.push_back(mk(1,0,0,0,          0,0,1, 1,32'h18, !c_JAL,d(32'h14),32'h14,0));
        vecs.push_back(mk(1,1,0,0,          0,0,1, 1,32'h18, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,          0,0,1, 1,32'h1C, 0,0,0,0));
        vecs.push_back(mk(1,0,1,d(32'h18),  0,0,1, 1,32'h1C, 0,0,0,0));
        vecs.push_back(mk(1,0,0,0,          0,0,1, 1,32'h1C, 1,d(32'h18),32'h18,0));
        for (int i = 0; i < vecs.size(); i++) apply(100 + i, vecs[i]);

        // Reset mid-run with three requests in flight, then a stray response
        vecs.delete();
        vecs.push_back(mk(1,1,0,0,        0,0,0, 1,32'h1C, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,        0,0,0, 1,32'h20, 0,0,0,0));
        vecs.push_back(mk(1,1,0,0,        0,0,0, 1,32'h24, 0,0,0,0));
        vecs.push_back(mk(0,1,0,0,        0,0,0, 0,32'h0,  0,0,0,0));
        vecs.push_back(mk(1,0,1,d(32'h1C),0,0,0, 1,32'h0,  0,0,0,0));
        vecs.push_back(mk(1,0,0,0,        0,0,1, 1,32'h0,  0,0,0,0));
        vecs.push_back(mk(1,1,0,0,        0,0,1, 1,32'h0,  0,0,0,0));
        vecs.push_back(mk(1,1,1,d(32'h0), 0,0,1, 1,32'h4,  0,0,0,0));
        vecs.push_back(mk(1,0,1,d(32'h4), 0,0,1, 1,32'h8,  1,d(32'h0),32'h0,0));
        vecs.push_back(mk(1,0,0,0,        0,0,1, 1,32'h8,  1,d(32'h4),32'h4,0));
        vecs.push_back(mk(1,0,0,0,        0,0,1, 1,32'h8,  0,0,0,0));
        for (int i = 0; i < vecs.size(); i++) apply(200 + i, vecs[i]);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
